// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory issue queue: micro-op encodings, packet
// layout and the branch kill/resolve helper also used by the memory and ALU stages.
package mem_issue_queue_pkg;

  localparam int IQ_WIDTH_Q   = 3;
  localparam int IQ_WIDTH_BRM = 4;
  localparam int IQ_WIDTH_REG = 5;
  localparam int IQ_WIDTH     = 4*32 + IQ_WIDTH_REG + IQ_WIDTH_BRM + 18;

  localparam logic [6:0] UOP_LOAD  = 7'b0000011;
  localparam logic [6:0] UOP_STORE = 7'b0100011;

  // Bit offsets of each field inside the flat packet, LSB field first.
  localparam int OFF_OP1    = 0;
  localparam int OFF_OP2    = OFF_OP1 + 32;
  localparam int OFF_IMM    = OFF_OP2 + 32;
  localparam int OFF_FUNC   = OFF_IMM + 32;
  localparam int OFF_PC     = OFF_FUNC + 10;
  localparam int OFF_RD     = OFF_PC + 32;
  localparam int OFF_BRMASK = OFF_RD + IQ_WIDTH_REG;
  localparam int OFF_UOP    = OFF_BRMASK + IQ_WIDTH_BRM;
  localparam int OFF_VAL    = OFF_UOP + 7;

  typedef struct packed {
    logic                    val;
    logic [6:0]              uop;
    logic [IQ_WIDTH_BRM-1:0] brmask;
    logic [IQ_WIDTH_REG-1:0] rd;
    logic [31:0]             pc;
    logic [9:0]              func;
    logic [31:0]             imm;
    logic [31:0]             op2;
    logic [31:0]             op1;
  } mem_pkt_t;

  // Returns {kill_hit, new_mask}. A bit present in both kill and ok still
  // kills, because the hit is taken from the mask before resolve clears it.
  function automatic logic [IQ_WIDTH_BRM:0] apply_br(
    input logic [IQ_WIDTH_BRM-1:0] mask,
    input logic [IQ_WIDTH_BRM-1:0] kill,
    input logic [IQ_WIDTH_BRM-1:0] ok
  );
    return {|(mask & kill), mask & ~ok};
  endfunction

endpackage

// File: rtl/mem_iq_entry.sv
// One issue-queue slot: holds a packet, applies kill/resolve every cycle and
// takes a new packet when written.
module mem_iq_entry
  import mem_issue_queue_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  mem_pkt_t                i_wdata,
  input  logic [IQ_WIDTH_BRM-1:0] i_brkill,
  input  logic [IQ_WIDTH_BRM-1:0] i_brok,
  output mem_pkt_t                o_pkt
);

  logic                  val_q, val_d;
  logic [IQ_WIDTH-2:0]   payload_q, payload_d;
  mem_pkt_t              cur, nxt;
  logic [IQ_WIDTH_BRM:0] br;

  assign cur   = {val_q, payload_q};
  assign o_pkt = cur;

  // Next slot contents: new packet on write, otherwise kill/resolve update.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    nxt = cur;
    br  = apply_br(cur.brmask, i_brkill, i_brok);
    if (i_we) begin
      nxt = i_wdata;
    end else begin
      nxt.val    = cur.val & ~br[IQ_WIDTH_BRM];
      nxt.brmask = br[IQ_WIDTH_BRM-1:0];
    end
    val_d     = nxt.val;
    payload_d = nxt[IQ_WIDTH-2:0];
  end

  // Valid bit: the only part of the slot that needs a reset value.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
    if (i_rst) val_q <= 1'b0;
    else       val_q <= val_d;
  end

  // Payload register.
  // NOTE: storage payload is not reset; val=0 makes stale contents harmless.
  always_ff @(posedge i_clk) begin
    payload_q <= payload_d;
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue between operand read and the memory stage.
// Stores wait at head for commit permission; loads and bubbles leave freely.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int WIDTH_Q   = IQ_WIDTH_Q,
  parameter int WIDTH_BRM = IQ_WIDTH_BRM,
  parameter int WIDTH_REG = IQ_WIDTH_REG,
  parameter int WIDTH     = 4*32 + WIDTH_REG + WIDTH_BRM + 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_instr,
  output logic                 o_ready,
  input  logic                 i_stall,
  input  logic                 i_st_ok,
  input  logic [WIDTH_BRM-1:0] i_brkill,
  input  logic [WIDTH_BRM-1:0] i_brok,
  output logic [WIDTH-1:0]     o_instr,
  output logic [WIDTH_Q:0]     o_count
);

  localparam int DEPTH = 1 << WIDTH_Q;
  typedef logic [WIDTH_Q:0] ptr_t;

  ptr_t     head_q, head_d, tail_q, tail_d, count_d;
  logic     ready_q, ready_d;
  mem_pkt_t out_q, out_d;

  mem_pkt_t in_pkt, in_upd, head_pkt, head_upd;
  mem_pkt_t entry_pkt [DEPTH];
  logic [DEPTH-1:0]   entry_we;
  logic [WIDTH_BRM:0] in_br, head_br, out_br;
  logic empty, is_store, deq, enq_wr;

  assign in_pkt   = mem_pkt_t'(i_instr);
  assign empty    = (head_q == tail_q);
  assign head_pkt = entry_pkt[head_q[WIDTH_Q-1:0]];

  // Storage slots, each applying kill/resolve to itself.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    mem_iq_entry u_entry (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (entry_we[g]),
      .i_wdata  (in_upd),
      .i_brkill (i_brkill),
      .i_brok   (i_brok),
      .o_pkt    (entry_pkt[g])
    );
  end

  // Enqueue: resolve the incoming mask; a killed packet is dropped.
  always_comb begin
    in_br         = apply_br(in_pkt.brmask, i_brkill, i_brok);
    in_upd        = in_pkt;
    in_upd.brmask = in_br[WIDTH_BRM-1:0];
    enq_wr        = in_pkt.val & ready_q & ~in_br[WIDTH_BRM];
    entry_we      = '0;
    if (enq_wr) entry_we[tail_q[WIDTH_Q-1:0]] = 1'b1;
  end

  // Dequeue decision on the head packet as seen after this cycle's kill/resolve.
  always_comb begin
    head_br         = apply_br(head_pkt.brmask, i_brkill, i_brok);
    head_upd        = head_pkt;
    head_upd.val    = head_pkt.val & ~head_br[WIDTH_BRM];
    head_upd.brmask = head_br[WIDTH_BRM-1:0];
    is_store        = head_upd.val && (head_upd.uop == UOP_STORE);
    deq             = !empty && !i_stall && (!is_store || i_st_ok);
  end

  // Pointer, occupancy and output-register next state.
  always_comb begin
    head_d  = head_q + ptr_t'(deq);
    tail_d  = tail_q + ptr_t'(enq_wr);
    count_d = tail_d - head_d;
    ready_d = (count_d != ptr_t'(DEPTH));

    out_br = apply_br(out_q.brmask, i_brkill, i_brok);
    out_d  = '0;
    if (deq) begin
      out_d = head_upd;
    end else if (i_stall) begin
      out_d        = out_q;
      out_d.val    = out_q.val & ~out_br[WIDTH_BRM];
      out_d.brmask = out_br[WIDTH_BRM-1:0];
    end
  end

  // Queue state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

  assign o_instr = out_q;
  assign o_ready = ready_q;
  assign o_count = tail_q - head_q;

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order buffer between the dispatch/operand-read stage and the memory-calculation stage.
- Accepts load/store micro-op packets, holds them in a circular FIFO and applies branch-kill and branch-resolve updates to queued entries.
- Releases one packet per cycle through a registered output, in the packet layout the memory stage consumes.
- A store leaves only when the commit logic grants it. Loads leave freely.

Parameters:
- WIDTH_Q, 3, log2 of queue depth (8 entries).
- WIDTH_BRM, 4, branch-mask width.
- WIDTH_REG, 5, destination register index width.
- WIDTH, 4*32+WIDTH_REG+WIDTH_BRM+18, packet width; packing {val[1], uop[7], brmask, rd, pc[32], func[10], imm[32], op2[32], op1[32]}, MSB first.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_instr  in  WIDTH  incoming packet; enqueue request = its val bit.
- o_ready  out  1  queue not full. Registered; an enqueue is accepted only when o_ready=1.
- i_stall  in  1  memory stage cannot accept; output register holds its value.
- i_st_ok  in  1  commit grants the store currently at head.
- i_brkill  in  WIDTH_BRM  mispredicted branch bits; kill any packet whose brmask ANDs non-zero.
- i_brok  in  WIDTH_BRM  correctly resolved branch bits; clear these bits in every mask.
- o_instr  out  WIDTH  packet to memory stage, registered.
- o_count  out  WIDTH_Q+1  current occupancy.

Behaviour:
- **Reset:** i_rst=1 at an edge sets head=tail=0, count=0, all entry val bits=0, o_instr=0 (val=0), o_ready=1. Reset mid-operation discards all contents.
- **Storage:** circular array of 2^WIDTH_Q entries. Pointers are WIDTH_Q+1 bits.
  - empty = (head==tail).
  - full = index bits equal and wrap bits differ.
  - o_count = tail-head.
- **Enqueue:**
  - Fires when i_instr.val=1 and o_ready=1; writes at tail, tail+1.
  - Written brmask = incoming brmask & ~i_brok.
  - If incoming brmask & i_brkill != 0, the packet is dropped and tail is not advanced.
  - An enqueue attempted while o_ready=0 is lost; upstream must hold it.
- **Kill/resolve:** applied every cycle to all entries, the output register and the incoming packet.
  - An entry or output whose brmask & i_brkill != 0 gets val=0.
  - All brmask bits in i_brok are cleared.
  - Kill takes precedence when the same bit appears in both vectors.
  - Killed entries stay in place as bubbles.
- **Head classification:**
  - uop 0000011 = load.
  - uop 0100011 = store.
  - Any other uop with val=1 is treated as a load, i.e. passes freely.
- **Dequeue:** fires when not empty, i_stall=0, and one of:
  - (a) head.val=0 (bubble), or
  - (b) head is a load, or
  - (c) head is a store and i_st_ok=1.
- **Dequeue effects:**
  - head+1.
  - o_instr <= head packet after same-cycle kill/resolve update. A bubble is output with val=0.
- **Idle cycles:**
  - i_stall=1: o_instr holds, but kill/resolve still apply to it.
  - i_stall=0 and no dequeue: o_instr.val <= 0; other fields don't care.
- **Store blocking:** a store at head without i_st_ok blocks all younger entries. Issue is strictly in order.
- **Latency:** a packet enqueued into an empty queue at edge N appears on o_instr at edge N+1 at the earliest. No same-cycle bypass.
- **Simultaneous enqueue/dequeue:** both take effect; count unchanged. When full, enqueue is refused even if a dequeue occurs that cycle, because o_ready is registered.
- **o_ready:** next-state = next count < 2^WIDTH_Q.

Decomposition:
- Shared package holds:
  - UOP_LOAD=7'b0000011, UOP_STORE=7'b0100011.
  - Field offset constants for the packet layout.
  - A function apply_br(mask, kill, ok) returning {kill_hit, new_mask}, reused by the memory and ALU stages.
- One sub-module, mem_iq_entry: a single entry register with its own kill/resolve update and write enable, instantiated 2^WIDTH_Q times.
- The queue top holds the pointers, dequeue logic and output register.

Test Plan:
1. Reset, then enqueue 3 loads (rd=1,2,3) with i_stall=0 → o_instr shows rd=1,2,3 with val=1 on 3 consecutive edges starting one edge after the first enqueue; o_count returns to 0.
2. Enqueue 8 packets with i_stall=1 → o_ready=0 after the 8th edge, o_count=8. A 9th enqueue is not stored. Release stall → 8 packets emerge in order and o_ready returns to 1.
3. Store (rd=4) at head followed by load (rd=5), i_st_ok=0 for 4 cycles → o_instr.val=0 throughout. Assert i_st_ok → store emerges, load follows next edge.
4. Queue entries with brmask 0001, 0010, 0001; pulse i_brkill=0001 → only the 0010 packet emerges with val=1; the other two emerge as val=0 bubbles; o_count reaches 0.
5. Entry with brmask 0011; pulse i_brok=0001 → emitted brmask=0010. Same cycle i_brkill=0010 and i_brok=0010 → packet killed.
6. Assert i_rst for one cycle with 5 entries queued and a valid o_instr → next edge o_count=0, o_instr.val=0, o_ready=1. A packet enqueued afterwards emerges normally.
